// File: rtl/decoder_seq_pkg.sv
// ============================================================================
// Module   : decoder_seq_pkg
// Brief    : Shared state encoding and mode constants for decoder_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module   : dwell_timer
// Brief    : Dwell counter with a latched limit; tick marks the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [DWELL_W-1:0] load_val,
    output logic               tick
);

    logic [DWELL_W-1:0] r_count;
    logic [DWELL_W-1:0] r_limit;

    assign tick = (r_count == r_limit);

    // The limit is re-sampled only on clear or expiry, so a new dwell value
    // never stretches or truncates the index currently being held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (clr || tick) begin
            r_count <= '0;
            r_limit <= load_val;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================================
// Module   : decoder_seq
// Brief    : Registered N-to-2^N active-low decoder with dwell-timed scan mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] W_n,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int               N_OUT      = 2**SEL_W;
    localparam logic [SEL_W-1:0] c_IDX_LAST = '1;

    state_e             r_state;
    state_e             w_next_state;
    logic [SEL_W-1:0]   r_idx;
    logic [N_OUT-1:0]   r_w_n;
    logic               r_wrap;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               w_wrap_nxt;
    logic [N_OUT-1:0]   w_dec_n;
    logic               w_tick;
    logic               w_clr;

    always_comb begin
        w_next_state = ST_IDLE;
        if (en) begin
            w_next_state = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    // Scan entry reloads from sel; only a scan already in progress advances.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        case (w_next_state)
            ST_DIRECT: w_idx_nxt = sel;
            ST_SCAN: begin
                if (r_state != ST_SCAN) begin
                    w_idx_nxt = sel;
                end else if (w_tick) begin
                    w_idx_nxt  = r_idx + 1'b1;
                    w_wrap_nxt = (r_idx == c_IDX_LAST);
                end
            end
            default: ;
        endcase
    end

    assign w_clr = (w_next_state != ST_SCAN) || (r_state != ST_SCAN);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_clr),
        .load_val (dwell),
        .tick     (w_tick)
    );

    generate
        for (genvar i = 0; i < N_OUT; i++) begin : g_dec
            assign w_dec_n[i] = (w_idx_nxt != SEL_W'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_w_n   <= '1;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_idx_nxt;
            r_wrap  <= w_wrap_nxt;
            r_w_n   <= (w_next_state == ST_IDLE) ? '1 : w_dec_n;
        end
    end

    assign W_n  = r_w_n;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================================
// Module   : tb_decoder_seq
// Brief    : Directed self-checking bench for decoder_seq (4- and 8-output).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_seq;

    typedef struct {
        int idx;
        int left;
        bit scan;
        bit active;
        bit wrap;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] sel4;
    logic [2:0] sel8;
    logic [3:0] dwell;
    logic [3:0] w_n4;
    logic [1:0] idx4;
    logic       wrap4;
    logic [7:0] w_n8;
    logic [2:0] idx8;
    logic       wrap8;

    int checks = 0;
    int errors = 0;
    model_t m4 = '{0, 0, 1'b0, 1'b0, 1'b0};
    model_t m8 = '{0, 0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel4),
        .dwell(dwell), .W_n(w_n4), .idx(idx4), .wrap(wrap4)
    );

    decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel8),
        .dwell(dwell), .W_n(w_n8), .idx(idx8), .wrap(wrap8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Countdown view of the scan: 'left' is how many more cycles the
    // current index stays after this one.
    function automatic model_t step(model_t m, int n, bit e, bit md, int s, int dw);
        model_t r = m;
        r.wrap = 1'b0;
        if (!e) begin
            r.active = 1'b0;
            r.scan   = 1'b0;
        end else if (!md) begin
            r.active = 1'b1;
            r.scan   = 1'b0;
            r.idx    = s;
        end else if (!m.scan) begin
            r.active = 1'b1;
            r.scan   = 1'b1;
            r.idx    = s;
            r.left   = dw;
        end else if (m.left == 0) begin
            r.idx  = (m.idx + 1) % n;
            r.wrap = (r.idx == 0);
            r.left = dw;
        end else begin
            r.left = m.left - 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_wn(model_t m);
        logic [7:0] one = 8'd1;
        return m.active ? ~(one << m.idx) : 8'hFF;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m4 <= '{0, 0, 1'b0, 1'b0, 1'b0};
            m8 <= '{0, 0, 1'b0, 1'b0, 1'b0};
        end else begin
            m4 <= step(m4, 4, en, mode, int'(sel4), int'(dwell));
            m8 <= step(m8, 8, en, mode, int'(sel8), int'(dwell));
        end
    end

    always @(negedge clk) begin
        logic [7:0] e4;
        e4 = exp_wn(m4);
        chk("model_w_n4", w_n4, e4[3:0]);
        chk("model_idx4", idx4, m4.idx);
        chk("model_wrap4", wrap4, m4.wrap);
        chk("model_w_n8", w_n8, exp_wn(m8));
        chk("model_idx8", idx8, m8.idx);
        chk("model_wrap8", wrap8, m8.wrap);
    end

    logic [3:0] dir_lit [4];
    int         scan_lit [9];
    int         wraps;

    initial begin
        dir_lit  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_lit = '{2, 2, 3, 3, 0, 0, 1, 1, 2};
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel4 = 2'd2; sel8 = 3'd0; dwell = 4'd3;

        repeat (2) @(negedge clk);
        chk("reset_w_n", w_n4, 4'b1111);
        chk("reset_idx", idx4, 0);
        chk("reset_wrap", wrap4, 0);

        rst_n = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            @(negedge clk);
            chk("direct_w_n", w_n4, dir_lit[s]);
            chk("direct_idx", idx4, s);
        end

        mode = 1'b1; sel4 = 2'd2; dwell = 4'd1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("scan_idx", idx4, scan_lit[k]);
            chk("scan_wrap", wrap4, (k == 4) ? 1 : 0);
        end

        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1; sel4 = 2'd3; dwell = 4'd0;
        @(negedge clk);
        chk("d0_idx_a", idx4, 3);
        chk("d0_wrap_a", wrap4, 0);
        @(negedge clk);
        chk("d0_idx_b", idx4, 0);
        chk("d0_wrap_b", wrap4, 1);
        @(negedge clk);
        chk("d0_idx_c", idx4, 1);
        dwell = 4'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("late_dwell_idx", idx4, (k < 3) ? 2 : 3);
        end

        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1; sel4 = 2'd1; dwell = 4'd3;
        @(negedge clk);
        chk("dis_pre_idx", idx4, 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_w_n", w_n4, 4'b1111);
        en = 1'b1; sel4 = 2'd3;
        @(negedge clk);
        chk("reen_idx", idx4, 3);
        chk("reen_w_n", w_n4, 4'b0111);

        // Edge where idx 3 would advance to 0 coincides with en falling.
        dwell = 4'd0;
        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1;
        @(negedge clk);
        chk("coinc_pre_idx", idx4, 3);
        en = 1'b0;
        @(negedge clk);
        chk("coinc_wrap", wrap4, 0);
        chk("coinc_w_n", w_n4, 4'b1111);

        en = 1'b1; sel4 = 2'd1; dwell = 4'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_w_n", w_n4, 4'b1111);
        chk("midrst_idx", idx4, 0);
        rst_n = 1'b1;

        mode = 1'b0; sel8 = 3'd0; dwell = 4'd0;
        @(negedge clk);
        mode = 1'b1;
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("sweep8_onehot", $countones(w_n8), 7);
            if (wrap8 === 1'b1) wraps++;
        end
        chk("sweep8_wraps", wraps, 1);
        chk("sweep8_end_idx", idx8, 7);

        en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered N-to-2^N decoder with active-low one-hot outputs and an auto-scan mode. It generalises the team's fixed 3-input NAND-gate decoder: output count scales with `SEL_W`, the outputs are registered, and a scan sequencer walks the active line through every output with a programmable dwell time. It drives row, chip-select and LED-strobe lines in lab designs where one output at a time must be asserted low.

## Interface
- `SEL_W`, default 2: select width; number of outputs `N_OUT = 2**SEL_W` (default 4).
- `DWELL_W`, default 4: width of the dwell-time input.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: block enable; 0 forces all outputs inactive.
- `mode`, input, 1: 0 = DIRECT (decode `sel`), 1 = SCAN (auto-advance).
- `sel`, input, SEL_W: decoded index in DIRECT mode; start index on SCAN entry.
- `dwell`, input, DWELL_W: each SCAN index is held for `dwell+1` cycles.
- `W_n`, output, N_OUT: active-low one-hot outputs; bit `i` is low when index `i` is selected.
- `idx`, output, SEL_W: currently asserted index.
- `wrap`, output, 1: one-cycle pulse when SCAN wraps from `N_OUT-1` to 0.

## Operation
- Reset (`rst_n=0` at a rising edge): `W_n` = all ones, `idx`=0, `wrap`=0, dwell count=0, state=IDLE. Reset overrides every other input.
- States: IDLE, DIRECT, SCAN. The next state is evaluated every cycle:
  - `en=0` → IDLE.
  - `en=1, mode=0` → DIRECT.
  - `en=1, mode=1` → SCAN.
- IDLE:
  - `W_n` = all ones, `wrap`=0.
  - `idx` holds its last value.
  - Dwell count is cleared.
- DIRECT:
  - `idx <= sel`, `W_n <= ~(1 << sel)`.
  - `sel` is re-sampled every cycle.
  - Dwell count is cleared, `wrap`=0.
- SCAN entry from IDLE or DIRECT:
  - `idx <= sel`, dwell count is cleared, `dwell` is latched.
- SCAN steady state:
  - The dwell count increments each cycle.
  - When count == latched dwell: count is cleared, `idx <= idx+1` modulo `N_OUT`, and `dwell` is re-latched.
  - `dwell` changes take effect only at the next index advance.
- Wrap:
  - `wrap`=1 in exactly the cycle where `idx` becomes 0 through an advance from `N_OUT-1`.
  - A SCAN entry with `sel=0` does not pulse `wrap`.
- Invariant: outside IDLE, exactly one bit of `W_n` is 0 and it equals bit `idx`.
- Mode change mid-scan (SCAN→DIRECT): takes effect the next cycle, and the scan position is discarded.
- `en` falling mid-scan: next cycle enters IDLE. Re-enabling SCAN restarts from `sel`, not from the old `idx`.
- Reset mid-scan: all state returns to reset values on that edge.

## Timing
- All outputs are registered. Input-to-`W_n` latency is 1 cycle; there is no combinational path from inputs to outputs.
- SCAN period per index is `dwell+1` cycles.
  - `dwell=0`: advance every cycle.
  - Full sweep is `N_OUT*(dwell+1)` cycles.
- `wrap` and the `W_n` bit-0 assertion appear in the same cycle.
- Simultaneous `en` deassert and index advance: IDLE wins; no `wrap` pulse is issued.

## Structure
- Package `decoder_seq_pkg`:
  - state enum (IDLE, DIRECT, SCAN);
  - mode constants `MODE_DIRECT=1'b0`, `MODE_SCAN=1'b1`.
- Sub-module `dwell_timer`:
  - parametrised by `DWELL_W`;
  - inputs `clk`, `rst_n`, `clr`, `load_val`;
  - output `tick` (count reached the latched value);
  - owns the dwell counter and the latched dwell.
- Top level holds the state register, the `idx` register and the output decode.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `en=1, mode=1` → `W_n=4'b1111`, `idx=0`, `wrap=0`.
- DIRECT decode: `en=1, mode=0`, sweep `sel` 0..3 one per cycle → one cycle later `W_n` = 1110, 1101, 1011, 0111 and `idx` tracks `sel`.
- SCAN with dwell: `sel=2, dwell=1`, enter SCAN →
  - `idx` sequence 2,2,3,3,0,0,1,1,2;
  - `wrap`=1 only in the first cycle of `idx=0`.
- Dwell=0 and late dwell change: `dwell=0` from `sel=3` → `idx` 3,0,1,… with `wrap` on the second cycle. Change `dwell` to 2 mid-index → the new period starts only after the next advance.
- Disable mid-scan: drop `en` while `idx=1` → next cycle `W_n=4'b1111`. Re-enable with `sel=3` → `idx=3`, not 2.
- Parameter sweep: `SEL_W=3`, `dwell=0` → 8-cycle sweep, exactly one `W_n` bit low every enabled cycle, one `wrap` per sweep.
